alu_bit_slice: RTL and testbench

- Registered 1-bit ALU slice supporting AND, OR, ADD/SUB and a compare ("set") function.
- Optional inversion on each operand gives NAND, NOR and subtract/compare variants.
- Intended as the per-bit building block of a ripple-carry N-bit ALU. Carry is exposed so slices can be chained.
- All outputs are registered on one clock.

---
 rtl/alu_bit_slice.sv | 97 +++++++++
 tb/tb_alu_bit_slice.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_bit_slice.sv
// -----------------------------------------------------------------------------
// alu_bit_slice
//
// Registered 1-bit ALU slice: AND, OR, ADD/SUB and a compare ("set") function,
// with optional inversion of either operand so that NAND, NOR, subtract and
// both magnitude-compare senses come from the same hardware. The carry is
// exposed so that N slices can be chained into a ripple-carry N-bit ALU.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high (priority over compute)
//   a, b       in   operand bits
//   Ainvert    in   1 = use ~a as the internal operand
//   Binvert    in   1 = use ~b as the internal operand
//   op[1:0]    in   00 AND, 01 OR, 10 SUM, 11 borrow indicator (~carry)
//   cy_in      in   adder carry in
//   result     out  registered result bit
//   zero_flag  out  registered, always the complement of result
//   cy_out     out  registered adder carry out (for every op)
//
// All outputs change one clock after the inputs; there is no handshake.
// -----------------------------------------------------------------------------
module alu_bit_slice (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       Ainvert,
  input  logic       Binvert,
  input  logic [1:0] op,
  input  logic       cy_in,
  output logic       result,
  output logic       zero_flag,
  output logic       cy_out
);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_SUM = 2'b10,
    OP_SET = 2'b11
  } op_e;

  logic w_aa;
  logic w_bb;
  logic w_sum;
  logic w_co;
  logic w_next_result;

  logic r_result;
  logic r_zero_flag;
  logic r_cy_out;

  // Operand conditioning: inverting B and forcing cy_in = 1 turns the adder
  // into a two's-complement subtractor.
  assign w_aa = Ainvert ? ~a : a;
  assign w_bb = Binvert ? ~b : b;

  // Full adder, always computed so cy_out is meaningful for every op.
  assign w_sum = w_aa ^ w_bb ^ cy_in;
  assign w_co  = (w_aa & w_bb) | (w_aa & cy_in) | (w_bb & cy_in);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // signal unassigned, which would otherwise infer a latch.
    w_next_result = 1'b0;
    unique case (op_e'(op))
      OP_AND: w_next_result = w_aa & w_bb;
      OP_OR:  w_next_result = w_aa | w_bb;
      OP_SUM: w_next_result = w_sum;
      // Missing carry out of (a + ~b + 1) means a borrow, i.e. a < b.
      OP_SET: w_next_result = ~w_co;
      default: w_next_result = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: reset is synchronous and wins over the computation; inputs are
      // ignored while it is high and the pending result is discarded.
      r_result    <= 1'b0;
      r_zero_flag <= 1'b1;
      r_cy_out    <= 1'b0;
    end else begin
      r_result    <= w_next_result;
      r_zero_flag <= ~w_next_result;
      r_cy_out    <= w_co;
    end
  end

  assign result    = r_result;
  assign zero_flag = r_zero_flag;
  assign cy_out    = r_cy_out;

endmodule

// File: tb/tb_alu_bit_slice.sv
// -----------------------------------------------------------------------------
// tb_alu_bit_slice
//
// Directed-vector bench for alu_bit_slice. The driver applies one vector per
// clock on the falling edge and pushes the hand-computed response into a
// queue; an independent monitor samples the outputs just after each rising
// edge and compares them against the queue head.
// -----------------------------------------------------------------------------
module tb_alu_bit_slice;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       Ainvert = 1'b0;
  logic       Binvert = 1'b0;
  logic [1:0] op = 2'b00;
  logic       cy_in = 1'b0;
  logic       result;
  logic       zero_flag;
  logic       cy_out;

  always #5 clk = ~clk;

  alu_bit_slice dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .Ainvert   (Ainvert),
    .Binvert   (Binvert),
    .op        (op),
    .cy_in     (cy_in),
    .result    (result),
    .zero_flag (zero_flag),
    .cy_out    (cy_out)
  );

  typedef struct {
    string name;
    logic  res;
    logic  zf;
    logic  cy;
    logic  chk_cy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vectors     = 0;
  int   n_miscompares = 0;
  bit   drive_done    = 1'b0;

  task automatic check(input string name, input logic act, input logic req);
    if (act !== req) begin
      n_miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // Apply one vector on the falling edge and queue its expected response.
  task automatic apply(input string name, input logic i_rst, input logic i_a,
                       input logic i_b, input logic i_ai, input logic i_bi,
                       input logic [1:0] i_op, input logic i_cin,
                       input logic e_res, input logic e_cy, input logic e_chk_cy);
    exp_t e;
    @(negedge clk);
    rst = i_rst; a = i_a; b = i_b; Ainvert = i_ai; Binvert = i_bi;
    op = i_op; cy_in = i_cin;
    e.name = name; e.res = e_res; e.zf = ~e_res; e.cy = e_cy; e.chk_cy = e_chk_cy;
    exp_q.push_back(e);
  endtask

  // Sweep (a,b) = 00,01,10,11; er/ec list expected values in that order (MSB first).
  task automatic sweep(input string name, input logic i_ai, input logic i_bi,
                       input logic [1:0] i_op, input logic i_cin,
                       input logic [3:0] er, input logic [3:0] ec);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      apply($sformatf("%s ab=%b", name, ab), 1'b0, ab[1], ab[0], i_ai, i_bi,
            i_op, i_cin, er[3-i], ec[3-i], 1'b1);
    end
  endtask

  // Monitor: compare the queue head against the outputs after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vectors++;
        check({e.name, " result"}, result, e.res);
        check({e.name, " zero_flag"}, zero_flag, e.zf);
        if (e.chk_cy) check({e.name, " cy_out"}, cy_out, e.cy);
        check({e.name, " zf==~result"}, zero_flag, ~result);
      end
    end
  end

  // Driver
  initial begin
    // Reset state
    apply("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    apply("reset1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);

    //     name    Ai    Bi    op     cin   result   cy_out
    sweep("AND",  1'b0, 1'b0, 2'b00, 1'b0, 4'b0001, 4'b0001);
    sweep("OR",   1'b0, 1'b0, 2'b01, 1'b0, 4'b0111, 4'b0001);
    sweep("NAND", 1'b1, 1'b1, 2'b01, 1'b0, 4'b1110, 4'b1000);
    sweep("NOR",  1'b1, 1'b1, 2'b00, 1'b0, 4'b1000, 4'b1000);
    sweep("ADD0", 1'b0, 1'b0, 2'b10, 1'b0, 4'b0110, 4'b0001);
    sweep("ADD1", 1'b0, 1'b0, 2'b10, 1'b1, 4'b1001, 4'b0111);
    sweep("SUB",  1'b0, 1'b1, 2'b10, 1'b1, 4'b0110, 4'b1011);
    sweep("SGT",  1'b1, 1'b0, 2'b11, 1'b1, 4'b0010, 4'b1101);
    // a < b sense of the compare: only a=0,b=1 sets
    sweep("SLT",  1'b0, 1'b1, 2'b11, 1'b1, 4'b0100, 4'b1011);

    // Reset mid-operation, input change under reset, then 1-cycle latency
    apply("pre_rst",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    apply("rst_hit",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    apply("rst_chg",  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
    apply("post_rst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    apply("next_vec", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
    end
    drive_done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  // Watchdog: the run is short; anything this long means the bench is stuck.
  initial begin
    #100000;
    if (!drive_done) begin
      $display("FAIL watchdog: run did not complete, expected completion by t=100000");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
